// File: rtl/cpu.sv
// GPIO display engine: registers GPIO_in, converts it to 8 packed BCD digits, and saturates values above 99_999_999.
// Optional macro CPU_OUTREG2_EN adds a mid-conversion register, giving a 3-cycle latency.
module cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] GPIO_in,
  output logic [31:0] GPIO_out
);

  localparam int unsigned IN_W   = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned OUT_W  = 4 * DIGITS;
  localparam int unsigned STEPS  = 27;
  localparam int unsigned SPLIT  = 14;
  localparam int unsigned SR_W   = OUT_W + STEPS;

  localparam logic [IN_W-1:0]  MAX_VAL = IN_W'(99_999_999);
  localparam logic [OUT_W-1:0] SAT_VAL = {DIGITS{4'h9}};

  // The shift register holds {bcd, remaining binary bits}. One step applies add-3, then shifts left by one.
  function automatic logic [SR_W-1:0] dd_steps(input logic [SR_W-1:0] sr_in, input int unsigned n);
    logic [SR_W-1:0] t;
    t = sr_in;
    for (int unsigned s = 0; s < n; s++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (t[STEPS + 4*d +: 4] >= 4'd5) begin
          t[STEPS + 4*d +: 4] = t[STEPS + 4*d +: 4] + 4'd3;
        end
      end
      t = t << 1;
    end
    return t;
  endfunction

  function automatic logic [OUT_W-1:0] dd_finish(input logic [SR_W-1:0] sr_in, input int unsigned n);
    logic [SR_W-1:0] t;
    t = dd_steps(sr_in, n);
    return t[SR_W-1 -: OUT_W];
  endfunction

  logic [IN_W-1:0]  in_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic             sat_d;

  assign sat_d    = (in_q > MAX_VAL);
  assign GPIO_out = out_q;

`ifdef CPU_OUTREG2_EN
  logic [SR_W-1:0] mid_q, mid_d;
  logic            sat_q;

  always_comb begin
    mid_d = dd_steps({OUT_W'(0), in_q[STEPS-1:0]}, SPLIT);
    out_d = sat_q ? SAT_VAL : dd_finish(mid_q, STEPS - SPLIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      mid_q <= '0;
      sat_q <= 1'b0;
      out_q <= '0;
    end else begin
      in_q  <= GPIO_in;
      mid_q <= mid_d;
      sat_q <= sat_d;
      out_q <= out_d;
    end
  end
`else
  always_comb begin
    out_d = sat_d ? SAT_VAL : dd_finish({OUT_W'(0), in_q[STEPS-1:0]}, STEPS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= GPIO_in;
      out_q <= out_d;
    end
  end
`endif

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: a decimal-arithmetic reference model is checked every cycle, plus literal expectations.
module tb_cpu;

`ifdef CPU_OUTREG2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] GPIO_in = 32'h0002_6789;
  logic [31:0] GPIO_out;

  always #5 clk = ~clk;

  cpu dut (
    .clk      (clk),
    .rst      (rst),
    .GPIO_in  (GPIO_in),
    .GPIO_out (GPIO_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] in_hist[$];
  logic        rst_hist[$];

  typedef struct {
    int          at;
    logic [31:0] v;
  } lit_t;
  lit_t lit_q[$];

  // Reference conversion: decimal digits from repeated division, saturating above 8 digits.
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0]     r;
    longint unsigned x;
    r = 32'h0;
    x = longint'(v);
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    in_hist.push_back(GPIO_in);
    rst_hist.push_back(rst);
  end

  // Output after edge k is zero if reset was seen within the last LAT edges, else the conversion of the sample from edge k-LAT+1.
  always @(negedge clk) begin
    int          n;
    logic        any_rst;
    logic [31:0] exp_v;
    cyc++;
    n = in_hist.size();
    any_rst = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      if (n - 1 - j < 0) any_rst = 1'b1;
      else if (rst_hist[n-1-j]) any_rst = 1'b1;
    end
    exp_v = any_rst ? 32'h0 : to_bcd(in_hist[n-LAT]);
    checks++;
    if (GPIO_out !== exp_v) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h exp=%h", cyc, GPIO_out, exp_v);
    end
    for (int i = lit_q.size() - 1; i >= 0; i--) begin
      if (lit_q[i].at == cyc) begin
        checks++;
        if (GPIO_out !== lit_q[i].v) begin
          errors++;
          $display("FAIL literal cyc=%0d got=%h exp=%h", cyc, GPIO_out, lit_q[i].v);
        end
        lit_q.delete(i);
      end
    end
  end

  task automatic step(input logic [31:0] v, input logic r);
    @(negedge clk);
    #1;
    GPIO_in = v;
    rst     = r;
  endtask

  task automatic expect_at(input int dly, input logic [31:0] v);
    lit_t e;
    e.at = cyc + dly;
    e.v  = v;
    lit_q.push_back(e);
  endtask

  task automatic apply(input logic [31:0] v, input logic [31:0] exp_v);
    step(v, 1'b0);
    expect_at(LAT, exp_v);
  endtask

  initial begin
    // Hold reset for 3 clocks; the output must stay zero.
    for (int i = 0; i < 3; i++) begin
      step(32'h0002_6789, 1'b1);
      expect_at(1, 32'h0);
    end
    apply(32'h0002_6789, 32'h0015_7577);
    for (int i = 0; i < LAT; i++) apply(32'h0002_6789, 32'h0015_7577);
    apply(32'h0003_FFFF, 32'h0026_2143);
    apply(32'h0000_0000, 32'h0000_0000);
    apply(32'h05F5_E0FF, 32'h9999_9999);
    apply(32'h05F5_E100, 32'h9999_9999);
    apply(32'hFFFF_FFFF, 32'h9999_9999);
    apply(32'h0800_0000, 32'h9999_9999);
    apply(32'd9,   32'h0000_0009);
    apply(32'd10,  32'h0000_0010);
    apply(32'd99,  32'h0000_0099);
    apply(32'd100, 32'h0000_0100);
    apply(32'd55_555_555, 32'h5555_5555);
    apply(32'd12_345_678, 32'h1234_5678);
    // A 1-cycle reset pulse while converting 123456 discards the in-flight samples.
    step(32'h0001_E240, 1'b0);
    step(32'h0001_E240, 1'b0);
    step(32'h0001_E240, 1'b1);
    expect_at(1, 32'h0);
    step(32'h0001_E240, 1'b0);
    expect_at(LAT - 1, 32'h0);
    expect_at(LAT, 32'h0012_3456);
    for (int i = 0; i < LAT + 2; i++) step(32'h0001_E240, 1'b0);
    if (lit_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL pending literal checks left=%0d exp=0", lit_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
